// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (IF) and memory (DM) stages.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise DM has fixed priority.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        stall_if,
    output logic        stall_dm,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arbState;

    localparam logic [2:0] waitInit = 3'(WAIT_STATES);

    arbState    state;
    arbState    stateNext;
    logic [2:0] cnt;
    logic       lastGrant;
    logic       isStore;
    logic       ifElig;
    logic       dmElig;
    logic       grantIf;
    logic       grantDm;

    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;

    // A request still high in its own ready cycle belongs to the retiring access.
    always_comb begin
        ifElig    = if_req & ~if_ready;
        dmElig    = dm_req & ~dm_ready;
        grantIf   = 1'b0;
        grantDm   = 1'b0;
        stateNext = state;
        case (state)
            IDLE: begin
                if (ifElig && dmElig) begin
`ifdef MEMARB_RR_EN
                    if (lastGrant) grantIf = 1'b1;
                    else           grantDm = 1'b1;
`else
                    grantDm = 1'b1;
`endif
                end else if (ifElig) begin
                    grantIf = 1'b1;
                end else if (dmElig) begin
                    grantDm = 1'b1;
                end
                if (grantIf)      stateNext = BUSY_I;
                else if (grantDm) stateNext = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (cnt == 3'd0) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            lastGrant <= 1'b0;
            isStore   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantIf || grantDm) begin
                        mem_en    <= 1'b1;
                        cnt       <= waitInit;
                        lastGrant <= grantDm;
                        isStore   <= grantDm & dm_we;
                        mem_addr  <= grantDm ? dm_addr : if_addr;
                        mem_wdata <= dm_wdata;
                        // With zero wait states the first access cycle is also the last.
                        mem_we    <= grantDm & dm_we & (waitInit == 3'd0);
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (cnt != 3'd0) begin
                        cnt    <= cnt - 3'd1;
                        mem_we <= isStore & (cnt == 3'd1);
                    end else begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == BUSY_I) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_ready <= 1'b1;
                            if (!isStore) dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
